// File: rtl/codec_tdm_intf.sv
// Serial audio codec port: derives MCLK/SCLK/LRCLK from clk and moves NUM_CH
// samples per frame over SDin/SDout in left-justified or I2S framing.
module codec_tdm_intf #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int SCLK_HALF = 16,
  parameter int MODE      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH*SAMPLE_W-1:0] tx_data,
  input  logic                       SDout,
  output logic                       MCLK,
  output logic                       SCLK,
  output logic                       LRCLK,
  output logic                       RSTn,
  output logic                       SDin,
  output logic [NUM_CH*SAMPLE_W-1:0] rx_data,
  output logic                       rx_valid,
  output logic                       busy
);

  localparam int DIV_N   = 2 * SCLK_HALF;
  localparam int DIV_W   = $clog2(DIV_N);
  localparam int BIT_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int SLT_W   = $clog2(NUM_CH);
  localparam int FRAME_W = NUM_CH * SAMPLE_W;

  if (SLOT_W < SAMPLE_W) begin : g_err_slot
    $error("codec_tdm_intf: SLOT_W must be >= SAMPLE_W");
  end
  if (MODE == 1 && SLOT_W <= SAMPLE_W) begin : g_err_i2s
    $error("codec_tdm_intf: I2S framing needs SLOT_W > SAMPLE_W");
  end
  if (MODE != 0 && MODE != 1) begin : g_err_mode
    $error("codec_tdm_intf: MODE must be 0 or 1");
  end
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_err_ch
    $error("codec_tdm_intf: NUM_CH must be 2..8");
  end
  if (SCLK_HALF < 2) begin : g_err_half
    $error("codec_tdm_intf: SCLK_HALF must be >= 2");
  end

  typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [SLT_W-1:0]   slot_q, slot_d;
  logic [1:0]         mclk_cnt_q;
  logic               sclk_q, lrclk_q, rstn_q, sdin_q, rx_valid_q, busy_q;
  logic [FRAME_W-1:0] rx_data_q, tx_sh_q, tx_sh_d, rx_pack;
  logic [SAMPLE_W-1:0] rx_sh_q [NUM_CH];
  logic               div_wrap, bit_wrap, frame_end, capture;

  // I2S shifts the sample window one SCLK later inside the slot.
  function automatic logic in_window(input int bitn);
    int p;
    p = bitn - MODE;
    return (p >= 0) && (p < SAMPLE_W);
  endfunction

  function automatic logic tx_bit(input logic [FRAME_W-1:0] shadow, input int slot,
                                  input int bitn);
    logic [FRAME_W-1:0] shifted;
    if (!in_window(bitn)) return 1'b0;
    shifted = shadow >> (slot * SAMPLE_W + SAMPLE_W - 1 - (bitn - MODE));
    return shifted[0];
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign rx_pack[c*SAMPLE_W +: SAMPLE_W] = rx_sh_q[c];
  end

  always_comb begin
    div_wrap  = (div_q == DIV_W'(DIV_N - 1));
    bit_wrap  = (bit_q == BIT_W'(SLOT_W - 1));
    frame_end = div_wrap && bit_wrap && (slot_q == SLT_W'(NUM_CH - 1));

    div_d  = div_wrap ? '0 : div_q + 1'b1;
    bit_d  = bit_q;
    slot_d = slot_q;
    if (div_wrap) begin
      bit_d = bit_wrap ? '0 : bit_q + 1'b1;
      if (bit_wrap) slot_d = (slot_q == SLT_W'(NUM_CH - 1)) ? '0 : slot_q + 1'b1;
    end

    state_d = state_q;
    if (frame_end) begin
      case (state_q)
        ST_STARTUP: state_d = ST_IDLE;
        ST_IDLE:    state_d = enable ? ST_RUN : ST_IDLE;
        ST_RUN:     state_d = enable ? ST_RUN : ST_IDLE;
        default:    state_d = ST_STARTUP;
      endcase
    end

    tx_sh_d = tx_sh_q;
    if (frame_end && state_d == ST_RUN) tx_sh_d = tx_data;

    capture = (state_q == ST_RUN) && (div_q == DIV_W'(SCLK_HALF - 1)) &&
              in_window(int'(bit_q));
  end

  // Control and output registers: SDin and LRCLK are computed from the
  // next-state counters so they change on the SCLK falling edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STARTUP;
      div_q      <= '0;
      bit_q      <= '0;
      slot_q     <= '0;
      mclk_cnt_q <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      rstn_q     <= 1'b0;
      sdin_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      slot_q     <= slot_d;
      mclk_cnt_q <= mclk_cnt_q + 2'd1;
      sclk_q     <= (div_d >= DIV_W'(SCLK_HALF));
      lrclk_q    <= (state_d == ST_STARTUP) || (slot_d == '0);
      rstn_q     <= (state_d != ST_STARTUP);
      sdin_q     <= (state_d == ST_RUN) && tx_bit(tx_sh_d, int'(slot_d), int'(bit_d));
      busy_q     <= (state_d == ST_RUN);
      rx_valid_q <= frame_end && (state_q == ST_RUN);
      if (frame_end && state_q == ST_RUN) rx_data_q <= rx_pack;
    end
  end

  // Datapath shift registers; every RUN frame fully rewrites them.
  always_ff @(posedge clk) begin
    tx_sh_q <= tx_sh_d;
    if (capture) rx_sh_q[slot_q] <= (rx_sh_q[slot_q] << 1) | SAMPLE_W'(SDout);
  end

  assign MCLK     = mclk_cnt_q[1];
  assign SCLK     = sclk_q;
  assign LRCLK    = lrclk_q;
  assign RSTn     = rstn_q;
  assign SDin     = sdin_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_codec_tdm_intf.sv
// Directed bench: default stereo loopback, I2S 24-bit slots against a codec
// model, and 4-channel TDM loopback, all sharing clk and rst.
module tb_codec_tdm_intf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en0, en1, en2;
  logic [31:0] tx0, tx1;
  logic [63:0] tx2;
  logic        sdout1;

  logic        mclk0, sclk0, lr0, rstn0, sdin0, rxv0, busy0;
  logic [31:0] rx0;
  logic        mclk1, sclk1, lr1, rstn1, sdin1, rxv1, busy1;
  logic [31:0] rx1;
  logic        mclk2, sclk2, lr2, rstn2, sdin2, rxv2, busy2;
  logic [63:0] rx2;

  codec_tdm_intf u_dut0 (
    .clk(clk), .rst(rst), .enable(en0), .tx_data(tx0), .SDout(sdin0),
    .MCLK(mclk0), .SCLK(sclk0), .LRCLK(lr0), .RSTn(rstn0), .SDin(sdin0),
    .rx_data(rx0), .rx_valid(rxv0), .busy(busy0)
  );

  codec_tdm_intf #(.SAMPLE_W(16), .SLOT_W(24), .NUM_CH(2), .SCLK_HALF(2), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .tx_data(tx1), .SDout(sdout1),
    .MCLK(mclk1), .SCLK(sclk1), .LRCLK(lr1), .RSTn(rstn1), .SDin(sdin1),
    .rx_data(rx1), .rx_valid(rxv1), .busy(busy1)
  );

  codec_tdm_intf #(.SAMPLE_W(16), .SLOT_W(16), .NUM_CH(4), .SCLK_HALF(16), .MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .enable(en2), .tx_data(tx2), .SDout(sdin2),
    .MCLK(mclk2), .SCLK(sclk2), .LRCLK(lr2), .RSTn(rstn2), .SDin(sdin2),
    .rx_data(rx2), .rx_valid(rxv2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;
  int n;

  int          v_cnt [3], v_t [3], v_tp [3], v_first [3], v_wide [3];
  logic        v_prev [3];
  logic [63:0] v_data [3];

  int   sclk_rise, sclk_first, mclk_rise, mclk_first;
  int   sclk_bad = 0, mclk_bad = 0, rx0_unstable = 0;
  int   lr0_low, sd0_ones;
  logic sclk0_prev, mclk0_prev;
  logic [31:0] rx0_prev;

  int          k1, ch1;
  logic        sclk1_prev, lr1_prev;
  logic [23:0] rec1, rec1_done0, rec1_done1, rec1_snap0, rec1_snap1;
  logic [15:0] word1, tmp1;
  int          lr2_hi, lr2_snap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon_valid(input int d, input logic v, input logic [63:0] data);
    if (v) begin
      if (v_prev[d]) v_wide[d]++;
      v_cnt[d]++;
      v_tp[d]   = v_t[d];
      v_t[d]    = n;
      v_data[d] = data;
      if (v_cnt[d] == 1) v_first[d] = n;
    end
    v_prev[d] = v;
  endtask

  task automatic reset_mon();
    n = 0;
    for (int d = 0; d < 3; d++) begin
      v_cnt[d] = 0; v_t[d] = 0; v_tp[d] = 0; v_first[d] = -1; v_wide[d] = 0;
      v_prev[d] = 1'b0; v_data[d] = '0;
    end
    sclk0_prev = sclk0; mclk0_prev = mclk0;
    sclk_rise = -1; sclk_first = -1; mclk_rise = -1; mclk_first = -1;
    lr0_low = 0; sd0_ones = 0; rx0_prev = rx0;
    k1 = 0; ch1 = 0; rec1 = '0; sclk1_prev = sclk1; lr1_prev = lr1;
    lr2_hi = 0; lr2_snap = 0;
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    mon_valid(0, rxv0, {32'h0, rx0});
    mon_valid(1, rxv1, {32'h0, rx1});
    mon_valid(2, rxv2, rx2);

    if (sclk0 && !sclk0_prev) begin
      if (sclk_rise >= 0) begin
        if (n - sclk_rise != 32) sclk_bad++;
      end else sclk_first = n;
      sclk_rise = n;
    end
    if (mclk0 && !mclk0_prev) begin
      if (mclk_rise >= 0) begin
        if (n - mclk_rise != 4) mclk_bad++;
      end else mclk_first = n;
      mclk_rise = n;
    end
    sclk0_prev = sclk0;
    mclk0_prev = mclk0;
    if (!lr0) lr0_low++;
    if (sdin0) sd0_ones++;
    if (rx0 !== rx0_prev && !rxv0) rx0_unstable++;
    rx0_prev = rx0;

    // I2S codec model: bit index restarts at the SCLK fall where LRCLK toggles.
    if (!sclk1 && sclk1_prev) begin
      if (lr1 != lr1_prev) k1 = 0;
      else k1++;
    end
    ch1   = lr1 ? 0 : 1;
    word1 = (ch1 == 0) ? 16'h8001 : 16'h7FFE;
    if (k1 >= 1 && k1 <= 16) begin
      tmp1   = word1 >> (16 - k1);
      sdout1 = tmp1[0];
    end else sdout1 = 1'b0;
    if (sclk1 && !sclk1_prev) begin
      rec1 = (k1 == 0) ? {23'h0, sdin1} : {rec1[22:0], sdin1};
      if (k1 == 23) begin
        if (ch1 == 0) rec1_done0 = rec1;
        else rec1_done1 = rec1;
      end
    end
    if (rxv1) begin
      rec1_snap0 = rec1_done0;
      rec1_snap1 = rec1_done1;
    end
    sclk1_prev = sclk1;
    lr1_prev   = lr1;

    if (rxv2) begin
      lr2_snap = lr2_hi;
      lr2_hi   = 0;
    end
    if (lr2) lr2_hi++;
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_mclk"},  mclk0, 1'b0);
    check({tag, "_sclk"},  sclk0, 1'b0);
    check({tag, "_lrclk"}, lr0,   1'b1);
    check({tag, "_rstn"},  rstn0, 1'b0);
    check({tag, "_sdin"},  sdin0, 1'b0);
    check({tag, "_rxdat"}, rx0,   32'h0);
    check({tag, "_rxv"},   rxv0,  1'b0);
    check({tag, "_busy"},  busy0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    tx0 = {16'hA5C3, 16'h1234};
    tx1 = {16'h8001, 16'h7FFE};
    tx2 = {16'h1000, 16'h0100, 16'h0010, 16'h0001};
    sdout1 = 1'b0;
    rec1_done0 = '0; rec1_done1 = '0; rec1_snap0 = '0; rec1_snap1 = '0;
    n = 0;
    repeat (3) @(negedge clk);
    chk_rst("init");
    rst = 1'b0;
    reset_mon();

    run_to(1023);
    check("rstn_before_boundary", rstn0, 1'b0);
    check("lrclk_low_in_startup", lr0_low, 0);
    run_to(1024);
    check("rstn_at_boundary", rstn0, 1'b1);
    check("sclk_first_rise", sclk_first, 16);
    check("mclk_first_rise", mclk_first, 2);
    run_to(2047);
    check("busy_idle", busy0, 1'b0);
    run_to(2048);
    check("busy_run", busy0, 1'b1);
    run_to(3071);
    check("no_valid_first_frame", v_cnt[0], 0);
    run_to(3072);
    check("first_valid_time", v_first[0], 3072);
    check("loop_rx_data", rx0, 32'hA5C3_1234);
    run_to(3073);
    check("valid_pulse_end", rxv0, 1'b0);
    run_to(3372);
    tx0 = {16'h0F0F, 16'hF00F};
    run_to(4096);
    check("inflight_valid_time", v_t[0], 4096);
    check("inflight_rx_data", v_data[0], 64'hA5C3_1234);
    run_to(4596);
    en0 = 1'b0;
    run_to(5119);
    check("busy_before_drop", busy0, 1'b1);
    run_to(5120);
    check("busy_after_drop", busy0, 1'b0);
    check("drop_valid_count", v_cnt[0], 3);
    check("drop_rx_data", v_data[0], 64'h0F0F_F00F);
    sd0_ones = 0;
    run_to(5420);
    en0 = 1'b1;
    run_to(6143);
    check("busy_wait_boundary", busy0, 1'b0);
    check("sdin_idle_zero", sd0_ones, 0);
    check("no_valid_in_idle", v_cnt[0], 3);
    run_to(6144);
    check("busy_resume", busy0, 1'b1);
    run_to(7168);
    check("resume_valid_count", v_cnt[0], 4);
    check("resume_valid_time", v_t[0], 7168);
    check("resume_rx_data", v_data[0], 64'h0F0F_F00F);

    run_to(8200);
    check("d0_valid_count", v_cnt[0], 5);
    check("d0_valid_width", v_wide[0], 0);
    check("d0_sclk_period", sclk_bad, 0);
    check("d0_mclk_period", mclk_bad, 0);
    check("d0_rx_stable", rx0_unstable, 0);
    check("i2s_first_valid", v_first[1], 576);
    check("i2s_frame_len", v_t[1] - v_tp[1], 192);
    check("i2s_rx_data", v_data[1], 64'h7FFE_8001);
    check("i2s_sdin_ch0", rec1_snap0, 24'h3FFF00);
    check("i2s_sdin_ch1", rec1_snap1, 24'h400080);
    check("i2s_valid_width", v_wide[1], 0);
    check("tdm_first_valid", v_first[2], 6144);
    check("tdm_frame_len", v_t[2] - v_tp[2], 2048);
    check("tdm_rx_data", v_data[2], 64'h1000_0100_0010_0001);
    check("tdm_lrclk_high", lr2_snap, 512);

    run_to(8422);
    check("busy_before_rst", busy0, 1'b1);
    rst = 1'b1;
    #1;
    chk_rst("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_mon();
    run_to(3071);
    check("post_rst_no_valid", v_cnt[0], 0);
    check("post_rst_rx_zero", rx0, 32'h0);
    run_to(3072);
    check("post_rst_first_valid", v_first[0], 3072);
    check("post_rst_rx_data", rx0, 32'h0F0F_F00F);
    check("post_rst_sclk_period", sclk_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
